// File: rtl/seg_scan_driver.sv
// +----------------------------------------------------------------------------+
// | seg_scan_driver: time-multiplexed hex digit scanner feeding a 7-seg decoder |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module seg_scan_driver #(
  parameter int NUM_DIGITS  = 8,
  parameter int REFRESH_DIV = 100000,
  parameter int GUARD       = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic                    data_valid,
  input  logic                    blank_lz,
  output logic [3:0]              ledBCD,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic                    frame_done,
  output logic                    update_pending
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [PW-1:0] c_tc    = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] c_guard = PW'(GUARD);
  localparam logic [IW-1:0] c_last  = IW'(NUM_DIGITS - 1);

  logic [PW-1:0]           r_pre;
  logic [IW-1:0]           r_idx;
  logic [4*NUM_DIGITS-1:0] r_pending;
  logic [4*NUM_DIGITS-1:0] r_display;

  logic                    w_tc;
  logic                    w_boundary;
  logic                    w_active;
  logic [3:0]              w_digit [NUM_DIGITS];
  logic [NUM_DIGITS:1]     w_upper_zero;
  logic [NUM_DIGITS-1:0]   w_blank;
  logic [NUM_DIGITS-1:0]   w_anode_next;

  assign w_tc       = (r_pre == c_tc);
  assign w_boundary = w_tc && (r_idx == c_last);
  assign w_active   = (r_pre >= c_guard);

  // Zero-run is evaluated from the most significant digit downwards.
  assign w_upper_zero[NUM_DIGITS] = 1'b1;

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    assign w_digit[i] = r_display[4*i +: 4];

    if (i == 0) begin : g_d0
      assign w_blank[i] = 1'b0;
    end else begin : g_dn
      if (i < NUM_DIGITS - 1) begin : g_mid
        assign w_upper_zero[i] = (w_digit[i] == 4'h0) && w_upper_zero[i+1];
      end else begin : g_top
        assign w_upper_zero[i] = (w_digit[i] == 4'h0);
      end
      assign w_blank[i] = blank_lz && w_upper_zero[i];
    end

    assign w_anode_next[i] = !(w_active && (r_idx == IW'(i)) && !w_blank[i]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pre          <= '0;
      r_idx          <= '0;
      r_pending      <= '0;
      r_display      <= '0;
      update_pending <= 1'b0;
      frame_done     <= 1'b0;
      ledBCD         <= 4'h0;
      anode          <= '1;
    end else begin
      if (w_tc) begin
        r_pre <= '0;
        r_idx <= (r_idx == c_last) ? '0 : r_idx + IW'(1);
      end else begin
        r_pre <= r_pre + PW'(1);
      end

      if (w_boundary && update_pending) begin
        r_display      <= r_pending;
        update_pending <= 1'b0;
      end

      // A strobe on the boundary cycle lands after the swap above and re-arms.
      if (data_valid) begin
        r_pending      <= data_in;
        update_pending <= 1'b1;
      end

      frame_done <= w_boundary;
      ledBCD     <= w_digit[r_idx];
      anode      <= w_anode_next;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver with 4 digits, 4-cycle slots, 1 guard cycle.
`default_nettype none

module tb_seg_scan_driver;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] data_in;
  logic        data_valid;
  logic        blank_lz;
  logic [3:0]  ledBCD;
  logic [3:0]  anode;
  logic        frame_done;
  logic        update_pending;

  int errors = 0;
  int checks = 0;

  seg_scan_driver #(
    .NUM_DIGITS (4),
    .REFRESH_DIV(4),
    .GUARD      (1)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .data_in       (data_in),
    .data_valid    (data_valid),
    .blank_lz      (blank_lz),
    .ledBCD        (ledBCD),
    .anode         (anode),
    .frame_done    (frame_done),
    .update_pending(update_pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] value;
    logic        blz;
    logic [3:0]  lit;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Entered one sample after a boundary; walks the 16 cycles of the next frame.
  task automatic check_frame(input logic [15:0] v, input logic [3:0] lit);
    logic [3:0] exp_an;
    int slot;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      slot   = k / 4;
      exp_an = 4'b1111;
      if ((k % 4) != 0 && lit[slot]) exp_an[slot] = 1'b0;
      chk("anode", {12'h0, anode}, {12'h0, exp_an});
      chk("ledBCD", {12'h0, ledBCD}, {12'h0, v[slot*4 +: 4]});
      chk("frame_done", {15'h0, frame_done}, {15'h0, (k == 15)});
    end
  endtask

  task automatic wait_frame(input int bound);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_done && n < bound);
    checks++;
    if (!frame_done) begin
      errors++;
      $display("FAIL wait_frame: frame_done never seen within %0d cycles", bound);
    end
  endtask

  task automatic strobe(input logic [15:0] v);
    data_in    = v;
    data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
  endtask

  initial begin
    vecs[0] = '{16'hA3C5, 1'b0, 4'b1111};
    vecs[1] = '{16'hA3C5, 1'b1, 4'b1111};
    vecs[2] = '{16'h000F, 1'b1, 4'b0001};
    vecs[3] = '{16'h000F, 1'b0, 4'b1111};
    vecs[4] = '{16'h0000, 1'b1, 4'b0001};
    vecs[5] = '{16'h0F00, 1'b1, 4'b0111};
    vecs[6] = '{16'h1000, 1'b1, 4'b1111};
    vecs[7] = '{16'h00F0, 1'b1, 4'b0011};

    rst_n      = 1'b0;
    data_in    = 16'h0;
    data_valid = 1'b0;
    blank_lz   = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_anode", {12'h0, anode}, 16'h000F);
    chk("rst_ledBCD", {12'h0, ledBCD}, 16'h0000);
    chk("rst_frame_done", {15'h0, frame_done}, 16'h0000);
    chk("rst_update_pending", {15'h0, update_pending}, 16'h0000);

    rst_n = 1'b1;
    check_frame(16'h0000, 4'b1111);

    for (int v = 0; v < 8; v++) begin
      blank_lz = vecs[v].blz;
      strobe(vecs[v].value);
      chk("pending_set", {15'h0, update_pending}, 16'h0001);
      wait_frame(32);
      chk("pending_clr", {15'h0, update_pending}, 16'h0000);
      check_frame(vecs[v].value, vecs[v].lit);
    end

    // New strobe on the boundary cycle: old pending swaps in, new one waits a frame.
    blank_lz = 1'b0;
    strobe(16'h00FF);
    repeat (14) @(negedge clk);
    data_in    = 16'h1234;
    data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
    chk("coinc_frame_done", {15'h0, frame_done}, 16'h0001);
    chk("coinc_pending", {15'h0, update_pending}, 16'h0001);
    check_frame(16'h00FF, 4'b1111);
    chk("coinc_pending_after", {15'h0, update_pending}, 16'h0000);
    check_frame(16'h1234, 4'b1111);

    // Asynchronous reset while digit 2 is lit, between clock edges.
    repeat (10) @(negedge clk);
    chk("pre_reset_anode", {12'h0, anode}, 16'h000B);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_anode", {12'h0, anode}, 16'h000F);
    chk("async_ledBCD", {12'h0, ledBCD}, 16'h0000);
    chk("async_pending", {15'h0, update_pending}, 16'h0000);
    chk("async_frame_done", {15'h0, frame_done}, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    check_frame(16'h0000, 4'b1111);

    for (int c = 0; c < 1000; c++) begin
      data_in    = 16'($urandom);
      data_valid = ($urandom_range(0, 7) == 0);
      blank_lz   = 1'($urandom);
      @(negedge clk);
      chk("one_hot_anode", 16'($countones(~anode) <= 1), 16'h0001);
    end
    data_valid = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

`default_nettype wire
